// File: rtl/axis_window_marker_pkg.sv
// Shared constants for the window-marker stream stages: tuser bit positions and width helper.
package axis_window_marker_pkg;

    localparam int SOF_BIT  = 0;
    localparam int NEED_BIT = 1;

    function automatic int tuser_width(input int need_width);
        return need_width + 1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry AXI4-Stream register slice: output register plus skid register, registered s_ready.
module axis_skid_buffer #(
    parameter int C_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    input  logic [C_WIDTH-1:0] s_data,
    output logic               s_ready,
    output logic               m_valid,
    output logic [C_WIDTH-1:0] m_data,
    input  logic               m_ready
);

    logic               skid_valid;
    logic               skid_valid_next;
    logic [C_WIDTH-1:0] skid_data;
    logic               in_fire;
    logic               out_open;

    assign in_fire  = s_valid & s_ready;
    assign out_open = ~m_valid | m_ready;

    // s_ready mirrors "skid empty"; a stalled output with an accepted beat parks it in the skid.
    always_comb begin
        skid_valid_next = skid_valid;
        if (out_open)
            skid_valid_next = 1'b0;
        else if (in_fire)
            skid_valid_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            s_ready    <= 1'b0;
        end else begin
            skid_valid <= skid_valid_next;
            s_ready    <= ~skid_valid_next;
            if (out_open) begin
                if (skid_valid) begin
                    m_valid <= 1'b1;
                    m_data  <= skid_data;
                end else begin
                    m_valid <= in_fire;
                    if (in_fire)
                        m_data <= s_data;
                end
            end else if (in_fire) begin
                skid_data <= s_data;
            end
        end
    end

endmodule

// File: rtl/axis_window_marker.sv
// Tags each pixel of a video stream with a need bit (tuser[1]) marking membership in a rectangular window.
module axis_window_marker
    import axis_window_marker_pkg::*;
#(
    parameter int C_PIXEL_WIDTH   = 24,
    parameter int C_IMG_BITS      = 12,
    parameter int C_IN_NEED_WIDTH = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       win_enable,
    input  logic [C_IMG_BITS-1:0]      win_left,
    input  logic [C_IMG_BITS-1:0]      win_top,
    input  logic [C_IMG_BITS-1:0]      win_width,
    input  logic [C_IMG_BITS-1:0]      win_height,
    input  logic                       s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_IN_NEED_WIDTH:0]   s_axis_tuser,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0]   m_axis_tdata,
    output logic [C_IN_NEED_WIDTH+1:0] m_axis_tuser,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready
);

    localparam int OUT_UW  = tuser_width(C_IN_NEED_WIDTH + 1);
    localparam int SLICE_W = OUT_UW + 1 + C_PIXEL_WIDTH;
    localparam logic [C_IMG_BITS-1:0] POS_MAX = '1;

    logic                  en_q;
    logic [C_IMG_BITS-1:0] left_q, top_q, width_q, height_q;
    logic [C_IMG_BITS-1:0] col_cnt, row_cnt;

    logic                  in_fire, sof;
    logic                  eff_en;
    logic [C_IMG_BITS-1:0] eff_left, eff_top, eff_width, eff_height;
    logic [C_IMG_BITS-1:0] col, row;
    logic [C_IMG_BITS:0]   col_end, row_end;
    logic                  need;
    logic [OUT_UW-1:0]     tuser_out;
    logic [SLICE_W-1:0]    slice_out;

    assign in_fire = s_axis_tvalid & s_axis_tready;
    assign sof     = s_axis_tuser[SOF_BIT];

    // The SOF beat is judged against the live win_* values it is about to latch.
    always_comb begin
        eff_en     = sof ? win_enable : en_q;
        eff_left   = sof ? win_left   : left_q;
        eff_top    = sof ? win_top    : top_q;
        eff_width  = sof ? win_width  : width_q;
        eff_height = sof ? win_height : height_q;
        col        = sof ? '0 : col_cnt;
        row        = sof ? '0 : row_cnt;
        col_end    = {1'b0, eff_left} + {1'b0, eff_width};
        row_end    = {1'b0, eff_top}  + {1'b0, eff_height};
        need       = eff_en & (row >= eff_top) & ({1'b0, row} < row_end)
                            & (col >= eff_left) & ({1'b0, col} < col_end);
    end

    always_comb begin
        tuser_out           = '0;
        tuser_out[SOF_BIT]  = sof;
        tuser_out[NEED_BIT] = need;
        for (int i = 0; i < C_IN_NEED_WIDTH; i++)
            tuser_out[NEED_BIT + 1 + i] = s_axis_tuser[SOF_BIT + 1 + i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q     <= 1'b0;
            left_q   <= '0;
            top_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else if (in_fire) begin
            if (sof) begin
                en_q     <= win_enable;
                left_q   <= win_left;
                top_q    <= win_top;
                width_q  <= win_width;
                height_q <= win_height;
            end
            // Counters saturate rather than wrap so oversized frames never re-enter the window.
            if (s_axis_tlast) begin
                col_cnt <= '0;
                row_cnt <= (row == POS_MAX) ? row : row + 1'b1;
            end else begin
                col_cnt <= (col == POS_MAX) ? col : col + 1'b1;
                row_cnt <= row;
            end
        end
    end

    axis_skid_buffer #(
        .C_WIDTH (SLICE_W)
    ) u_slice (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_axis_tvalid),
        .s_data  ({tuser_out, s_axis_tlast, s_axis_tdata}),
        .s_ready (s_axis_tready),
        .m_valid (m_axis_tvalid),
        .m_data  (slice_out),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = slice_out;

endmodule

// File: tb/tb_axis_window_marker.sv
// Scoreboard bench for axis_window_marker: expected beats queued at drive time, compared at output.
module tb_axis_window_marker;

    localparam int PW     = 24;
    localparam int IB     = 12;
    localparam int NW     = 1;
    localparam int UW_IN  = NW + 1;
    localparam int UW_OUT = NW + 2;
    localparam int VW     = UW_OUT + 1 + PW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              win_enable = 1'b0;
    logic [IB-1:0]     win_left = '0, win_top = '0, win_width = '0, win_height = '0;
    logic              s_valid = 1'b0;
    logic [PW-1:0]     s_data = '0;
    logic [UW_IN-1:0]  s_user = '0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              m_valid;
    logic [PW-1:0]     m_data;
    logic [UW_OUT-1:0] m_user;
    logic              m_last;
    logic              m_ready = 1'b1;

    logic [VW-1:0] exp_q[$];
    int  vectors = 0, errors = 0;
    int  rx_beats = 0, rx_need = 0;
    bit  rand_valid = 0, rand_ready = 0;
    bit  hold_pending = 0;
    logic [VW-1:0] held;

    always #5 clk = ~clk;

    axis_window_marker #(
        .C_PIXEL_WIDTH   (PW),
        .C_IMG_BITS      (IB),
        .C_IN_NEED_WIDTH (NW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .win_enable    (win_enable),
        .win_left      (win_left),
        .win_top       (win_top),
        .win_width     (win_width),
        .win_height    (win_height),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tuser  (s_user),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
        .m_axis_tuser  (m_user),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready)
    );

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        logic [VW-1:0] obs, exp_v;
        obs = {m_user, m_last, m_data};
        if (reset) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                vectors++;
                if (m_valid !== 1'b1 || obs !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h", m_valid, obs, held);
                end
            end
            hold_pending = 0;
            if (m_valid === 1'b1) begin
                if (m_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got %h, required no beat", obs);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (obs !== exp_v) begin
                            errors++;
                            $display("FAIL beat %0d: got user=%b last=%b data=%h, required user=%b last=%b data=%h",
                                     rx_beats, m_user, m_last, m_data,
                                     exp_v[VW-1 -: UW_OUT], exp_v[PW], exp_v[PW-1:0]);
                        end
                    end
                    rx_beats++;
                    if (m_user[1]) rx_need++;
                end else begin
                    hold_pending = 1;
                    held = obs;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [PW-1:0] d, input logic [UW_IN-1:0] u, input logic l);
        bit ok;
        int n;
        if (rand_valid)
            while ($urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        s_valid = 1'b1; s_data = d; s_user = u; s_last = l;
        n = 0;
        forever begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n >= 1000) begin
                vectors++; errors++;
                $display("FAIL accept_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    // nbeats < 0 sends the whole frame; with_sof=0 models a stream seen before any SOF (shadow en=0).
    task automatic send_frame(input int w, input int h, input bit en, input int left, input int top,
                              input int ww, input int wh, input int nbeats, input bit with_sof,
                              input int chg_row, input int chg_left);
        int k;
        bit sof, last, need, up;
        logic [PW-1:0] d;
        win_enable = en; win_left = left[IB-1:0]; win_top = top[IB-1:0];
        win_width = ww[IB-1:0]; win_height = wh[IB-1:0];
        k = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (nbeats >= 0 && k >= nbeats) return;
                if (r == chg_row && c == 0) win_left = chg_left[IB-1:0];
                d    = PW'($urandom);
                up   = 1'($urandom_range(0, 1));
                sof  = with_sof && r == 0 && c == 0;
                last = (c == w - 1);
                need = with_sof && en && r >= top && r < top + wh && c >= left && c < left + ww;
                exp_q.push_back({up, need, sof, last, d});
                send_beat(d, {up, sof}, last);
                k++;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++; errors++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        vectors++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b, required 0", s_ready); end
        @(posedge clk); #1;
        vectors++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b, required 1", s_ready); end
        vectors++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_m_valid: got %b, required 0", m_valid); end
    endtask

    task automatic test_basic();
        time t0, t1;
        rx_beats = 0; rx_need = 0;
        t0 = $time;
        send_frame(10, 8, 1, 3, 2, 3, 4, -1, 1, -1, 0);
        t1 = $time;
        @(negedge clk); #1;
        vectors++;
        if (rx_beats != 80) begin errors++; $display("FAIL basic_latency: got %0d beats out, required 80", rx_beats); end
        vectors++;
        if ((t1 - t0) / 10 != 80) begin errors++; $display("FAIL basic_throughput: got %0d cycles, required 80", (t1 - t0) / 10); end
        vectors++;
        if (rx_need != 12) begin errors++; $display("FAIL basic_need_count: got %0d, required 12", rx_need); end
        wait_drain();
    endtask

    task automatic test_random();
        rx_beats = 0; rx_need = 0;
        rand_valid = 1; rand_ready = 1;
        send_frame(10, 8, 1, 3, 2, 3, 4, -1, 1, -1, 0);
        wait_drain();
        rand_valid = 0; rand_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (rx_beats != 80) begin errors++; $display("FAIL random_beats: got %0d, required 80", rx_beats); end
        vectors++;
        if (rx_need != 12) begin errors++; $display("FAIL random_need_count: got %0d, required 12", rx_need); end
    endtask

    task automatic test_window_change();
        rx_need = 0;
        send_frame(10, 8, 1, 3, 2, 3, 4, -1, 1, 4, 6);
        wait_drain();
        vectors++;
        if (rx_need != 12) begin errors++; $display("FAIL change_frame1_need: got %0d, required 12", rx_need); end
        rx_need = 0;
        send_frame(10, 8, 1, 6, 2, 3, 4, -1, 1, -1, 0);
        wait_drain();
        vectors++;
        if (rx_need != 12) begin errors++; $display("FAIL change_frame2_need: got %0d, required 12", rx_need); end
    endtask

    task automatic test_clip();
        rx_beats = 0; rx_need = 0;
        send_frame(4096, 2, 1, 4094, 0, 4, 1, -1, 1, -1, 0);
        wait_drain();
        vectors++;
        if (rx_need != 2) begin errors++; $display("FAIL clip_need_count: got %0d, required 2", rx_need); end
        vectors++;
        if (rx_beats != 8192) begin errors++; $display("FAIL clip_beats: got %0d, required 8192", rx_beats); end
    endtask

    task automatic test_zero();
        rx_beats = 0; rx_need = 0;
        send_frame(10, 8, 1, 3, 2, 0, 4, -1, 1, -1, 0);
        wait_drain();
        vectors++;
        if (rx_need != 0) begin errors++; $display("FAIL zero_width_need: got %0d, required 0", rx_need); end
        rx_need = 0;
        send_frame(10, 8, 0, 0, 0, 10, 8, -1, 1, -1, 0);
        wait_drain();
        vectors++;
        if (rx_need != 0) begin errors++; $display("FAIL disabled_need: got %0d, required 0", rx_need); end
        vectors++;
        if (rx_beats != 160) begin errors++; $display("FAIL zero_beats: got %0d, required 160", rx_beats); end
    endtask

    task automatic test_reset_midframe();
        send_frame(10, 8, 1, 0, 0, 10, 8, 35, 1, -1, 0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        vectors++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_idle: got valid=%b ready=%b, required 0 0", m_valid, s_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL midreset_hold: got valid=%b ready=%b, required 0 0", m_valid, s_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        rx_need = 0;
        send_frame(10, 8, 1, 0, 0, 10, 8, 5, 0, -1, 0);
        wait_drain();
        vectors++;
        if (rx_need != 0) begin errors++; $display("FAIL pre_sof_need: got %0d, required 0", rx_need); end
        rx_need = 0; rx_beats = 0;
        send_frame(10, 8, 1, 3, 2, 3, 4, -1, 1, -1, 0);
        wait_drain();
        vectors++;
        if (rx_need != 12) begin errors++; $display("FAIL post_reset_need: got %0d, required 12", rx_need); end
        vectors++;
        if (rx_beats != 80) begin errors++; $display("FAIL post_reset_beats: got %0d, required 80", rx_beats); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_window_change();
        test_clip();
        test_zero();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
